// File: rtl/wb_burst_master_if.sv
// Host command/data streams plus Wishbone classic master signals for wb_burst_master.
interface wb_burst_master_if;
  localparam int unsigned ADR_W = 8;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned DAT_W = 32;

  // host command stream
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [ADR_W-1:0] cmd_adr;
  logic [LEN_W-1:0] cmd_len;
  // host write-data stream
  logic             wdat_valid;
  logic             wdat_ready;
  logic [DAT_W-1:0] wdat;
  // host read-data stream
  logic             rdat_valid;
  logic             rdat_ready;
  logic [DAT_W-1:0] rdat;
  // burst status pulses
  logic             done;
  logic             err;
  // Wishbone classic
  logic [ADR_W-1:0] ADR_O;
  logic [DAT_W-1:0] DAT_O;
  logic [DAT_W-1:0] DAT_I;
  logic             WE_O;
  logic             CYC_O;
  logic             STB_O;
  logic             ACK_I;

  modport master (
    input  cmd_valid, cmd_write, cmd_adr, cmd_len, wdat_valid, wdat, rdat_ready, DAT_I, ACK_I,
    output cmd_ready, wdat_ready, rdat_valid, rdat, done, err, ADR_O, DAT_O, WE_O, CYC_O, STB_O
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_adr, cmd_len, wdat_valid, wdat, rdat_ready, DAT_I, ACK_I,
    input  cmd_ready, wdat_ready, rdat_valid, rdat, done, err, ADR_O, DAT_O, WE_O, CYC_O, STB_O
  );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone classic burst master: turns host burst commands into single-beat cycles,
// holding CYC_O for the whole burst and aborting on an ACK timeout.
module wb_burst_master #(
  parameter int unsigned ADR_STEP    = 1,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic CLK_I,
  input logic RST_I,
  wb_burst_master_if.master bus
);
  localparam int unsigned ADR_W = 8;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned TMO_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    WDAT,
    BUS,
    RHOLD,
    DONE,
    ERR
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_q;
  logic [TMO_W-1:0] tmo_q;
  logic [ADR_W-1:0] adr_q;
  logic [DAT_W-1:0] dat_q;
  logic [DAT_W-1:0] rdat_q;
  logic             we_q;
  logic             cyc_q;
  logic             stb_q;
  logic             rdat_valid_q;
  logic             done_q;
  logic             err_q;

  logic last_beat;
  logic tmo_hit;

  assign last_beat = (beat_q == len_q);
  assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  // Ready signals are state decodes; gated by reset so they read 0 while RST_I is high.
  assign bus.cmd_ready  = (state == IDLE) & ~RST_I;
  assign bus.wdat_ready = (state == WDAT) & bus.wdat_valid & ~RST_I;

  assign bus.ADR_O      = adr_q;
  assign bus.DAT_O      = dat_q;
  assign bus.WE_O       = we_q;
  assign bus.CYC_O      = cyc_q;
  assign bus.STB_O      = stb_q;
  assign bus.rdat       = rdat_q;
  assign bus.rdat_valid = rdat_valid_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

  // Burst FSM with all bus and stream outputs registered.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state        <= IDLE;
      len_q        <= '0;
      beat_q       <= '0;
      tmo_q        <= '0;
      adr_q        <= '0;
      dat_q        <= '0;
      rdat_q       <= '0;
      we_q         <= 1'b0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      rdat_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            adr_q  <= bus.cmd_adr;
            len_q  <= bus.cmd_len;
            beat_q <= '0;
            tmo_q  <= '0;
            we_q   <= bus.cmd_write;
            cyc_q  <= 1'b1;
            if (bus.cmd_write) begin
              state <= WDAT;
            end else begin
              stb_q <= 1'b1;
              state <= BUS;
            end
          end
        end
        WDAT: begin
          if (bus.wdat_valid) begin
            dat_q <= bus.wdat;
            stb_q <= 1'b1;
            tmo_q <= '0;
            state <= BUS;
          end
        end
        BUS: begin
          // An ACK in the timeout cycle still completes the beat.
          if (bus.ACK_I) begin
            stb_q <= 1'b0;
            adr_q <= adr_q + ADR_W'(ADR_STEP);
            if (we_q) begin
              if (last_beat) begin
                cyc_q  <= 1'b0;
                we_q   <= 1'b0;
                done_q <= 1'b1;
                state  <= DONE;
              end else begin
                beat_q <= beat_q + LEN_W'(1);
                state  <= WDAT;
              end
            end else begin
              rdat_q       <= bus.DAT_I;
              rdat_valid_q <= 1'b1;
              state        <= RHOLD;
            end
          end else if (tmo_hit) begin
            stb_q        <= 1'b0;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            rdat_valid_q <= 1'b0;
            err_q        <= 1'b1;
            state        <= ERR;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        RHOLD: begin
          // Host backpressure: no new strobe until the read word is taken.
          if (bus.rdat_ready) begin
            rdat_valid_q <= 1'b0;
            if (last_beat) begin
              cyc_q  <= 1'b0;
              we_q   <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              beat_q <= beat_q + LEN_W'(1);
              stb_q  <= 1'b1;
              tmo_q  <= '0;
              state  <= BUS;
            end
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: table of burst vectors plus a mid-burst reset sequence.
module tb_wb_burst_master;
  logic clk;
  logic rst;

  wb_burst_master_if bus ();

  wb_burst_master #(.ADR_STEP(1), .TIMEOUT_CYC(255)) dut (
    .CLK_I (clk),
    .RST_I (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       write;
    logic [7:0] adr;
    logic [3:0] len;
    int         ack_dly;      // cycles of STB before ACK; -1 = never
    int         wgap;         // cycles wdat_valid is withheld after each word
    int         rstall;       // cycles rdat_ready is held low after the first read word
    logic       exp_done;
    logic       exp_err;
    int         exp_stb;      // total STB_O-high cycles
    logic [7:0] exp_last_adr; // ADR_O of final beat
  } vec_t;

  vec_t vecs[6];
  int   ncmp;
  int   nfail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_burst(input vec_t v, input string tag);
    logic [7:0]  badr[16];
    logic [31:0] bdat[16];
    logic        bwe[16];
    logic [31:0] rwords[16];
    int nb, nr, wsent, gap, stall_left, stb_age, stb_cyc, stall_stb, cyc_drop, ndone, nerr;
    logic stalling, ended, finished;
    nb = 0; nr = 0; wsent = 0; gap = 0; stall_left = v.rstall; stb_age = 0;
    stb_cyc = 0; stall_stb = 0; cyc_drop = 0; ndone = 0; nerr = 0;
    stalling = 1'b0; ended = 1'b0; finished = 1'b0;

    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.write;
    bus.cmd_adr   = v.adr;
    bus.cmd_len   = v.len;
    #1;
    chk({tag, "_cmd_ready_idle"}, 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    #1;
    chk({tag, "_cmd_ready_busy"}, 32'(bus.cmd_ready), 32'd0);

    for (int c = 0; c < 600; c++) begin
      if (c > 0) @(negedge clk);
      bus.ACK_I = bus.STB_O && (v.ack_dly >= 0) && (stb_age >= v.ack_dly);
      bus.DAT_I = 32'(32'h11 * (nb + 1));
      if (v.write) begin
        if (gap > 0) begin
          gap--;
          bus.wdat_valid = 1'b0;
        end else begin
          bus.wdat_valid = (wsent <= int'(v.len)) && !ended;
        end
        bus.wdat = 32'(32'hA0 + wsent);
      end else begin
        bus.wdat_valid = 1'b0;
      end
      if (bus.rdat_valid && nr == 0 && stall_left > 0) begin
        bus.rdat_ready = 1'b0;
        stall_left--;
        stalling = 1'b1;
      end else begin
        bus.rdat_ready = 1'b1;
        stalling = 1'b0;
      end
      #1;
      if (ended) begin
        chk({tag, "_cmd_ready_after"}, 32'(bus.cmd_ready), 32'd1);
        finished = 1'b1;
        break;
      end
      if (bus.STB_O) stb_cyc++;
      if (stalling && bus.STB_O) stall_stb++;
      if (!bus.CYC_O && !bus.done && !bus.err) cyc_drop++;
      if (bus.done) ndone++;
      if (bus.err) nerr++;
      if (bus.done || bus.err) begin
        ended = 1'b1;
        chk({tag, "_cyc_at_end"}, 32'(bus.CYC_O), 32'd0);
        chk({tag, "_stb_at_end"}, 32'(bus.STB_O), 32'd0);
      end
      if (bus.STB_O && bus.ACK_I) begin
        if (nb < 16) begin
          badr[nb] = bus.ADR_O;
          bdat[nb] = bus.DAT_O;
          bwe[nb]  = bus.WE_O;
        end
        nb++;
        stb_age = 0;
      end else if (bus.STB_O) begin
        stb_age++;
      end
      if (bus.rdat_valid && bus.rdat_ready) begin
        if (nr < 16) rwords[nr] = bus.rdat;
        nr++;
      end
      if (bus.wdat_valid && bus.wdat_ready) begin
        wsent++;
        gap = v.wgap;
      end
    end
    bus.ACK_I = 1'b0;
    bus.wdat_valid = 1'b0;

    ncmp++;
    if (!finished) begin
      nfail++;
      $display("FAIL %s_burst_end: got no completion expected done/err within 600 cycles", tag);
    end
    chk({tag, "_done_cnt"}, 32'(ndone), 32'(v.exp_done));
    chk({tag, "_err_cnt"}, 32'(nerr), 32'(v.exp_err));
    chk({tag, "_stb_cycles"}, 32'(stb_cyc), 32'(v.exp_stb));
    chk({tag, "_cyc_continuous"}, 32'(cyc_drop), 32'd0);
    chk({tag, "_stb_in_stall"}, 32'(stall_stb), 32'd0);
    chk({tag, "_beats"}, 32'(nb), v.exp_done ? 32'(int'(v.len) + 1) : 32'd0);
    if (v.exp_done && nb == int'(v.len) + 1) begin
      chk({tag, "_last_adr"}, 32'(badr[nb-1]), 32'(v.exp_last_adr));
      for (int i = 0; i < nb; i++) begin
        chk($sformatf("%s_adr%0d", tag, i), 32'(badr[i]), 32'(8'(v.adr + 8'(i))));
        chk($sformatf("%s_we%0d", tag, i), 32'(bwe[i]), 32'(v.write));
        if (v.write)
          chk($sformatf("%s_wdat%0d", tag, i), bdat[i], 32'(32'hA0 + i));
      end
      if (!v.write) begin
        chk({tag, "_rwords"}, 32'(nr), 32'(nb));
        for (int i = 0; i < nr && i < 16; i++)
          chk($sformatf("%s_rdat%0d", tag, i), rwords[i], 32'(32'h11 * (i + 1)));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t rv;
    int   nb;
    logic hit;
    ncmp = 0;
    nfail = 0;
    //          wr    adr    len   dly  gap stall done  err  stb  last
    vecs[0] = '{1'b1, 8'h10, 4'd3, 0,   0,  0,    1'b1, 1'b0, 4,   8'h13};
    vecs[1] = '{1'b0, 8'hFE, 4'd2, 0,   0,  5,    1'b1, 1'b0, 3,   8'h00};
    vecs[2] = '{1'b1, 8'h60, 4'd0, -1,  0,  0,    1'b0, 1'b1, 255, 8'h60};
    vecs[3] = '{1'b1, 8'h40, 4'd0, 254, 0,  0,    1'b1, 1'b0, 255, 8'h40};
    vecs[4] = '{1'b1, 8'h80, 4'd1, 2,   10, 0,    1'b1, 1'b0, 6,   8'h81};
    vecs[5] = '{1'b0, 8'h20, 4'd0, 3,   0,  0,    1'b1, 1'b0, 4,   8'h20};

    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_adr = '0; bus.cmd_len = '0;
    bus.wdat_valid = 1'b0; bus.wdat = '0; bus.rdat_ready = 1'b0;
    bus.DAT_I = '0; bus.ACK_I = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cyc", 32'(bus.CYC_O), 32'd0);
    chk("rst_stb", 32'(bus.STB_O), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_done_err", 32'({bus.done, bus.err, bus.rdat_valid}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    for (int k = 0; k < 6; k++) run_burst(vecs[k], $sformatf("v%0d", k));

    // ACK while waiting for write data must be ignored
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_adr = 8'h70; bus.cmd_len = 4'd0;
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.ACK_I = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("ack_in_wdat_stb", 32'(bus.STB_O), 32'd0);
    chk("ack_in_wdat_done", 32'(bus.done), 32'd0);
    chk("ack_in_wdat_cyc", 32'(bus.CYC_O), 32'd1);
    bus.ACK_I = 1'b0;
    bus.wdat = 32'h5A5A5A5A; bus.wdat_valid = 1'b1;
    @(negedge clk);
    bus.wdat_valid = 1'b0; bus.ACK_I = 1'b1;
    #1;
    chk("ack_in_wdat_dat", bus.DAT_O, 32'h5A5A5A5A);
    chk("ack_in_wdat_adr", 32'(bus.ADR_O), 32'h70);
    @(negedge clk);
    bus.ACK_I = 1'b0;
    #1;
    chk("ack_in_wdat_fin", 32'(bus.done), 32'd1);
    @(negedge clk);

    // Reset in the middle of a 4-beat read
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_adr = 8'h30; bus.cmd_len = 4'd3;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    nb = 0;
    hit = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (c > 0) @(negedge clk);
      bus.rdat_ready = 1'b1;
      bus.DAT_I = 32'(32'h11 * (nb + 1));
      bus.ACK_I = bus.STB_O;
      #1;
      if (bus.STB_O && nb == 1) begin
        hit = 1'b1;
        break;
      end
      if (bus.STB_O && bus.ACK_I) nb++;
    end
    chk("mid_rst_reached_beat2", 32'(hit), 32'd1);
    rst = 1'b1;
    bus.ACK_I = 1'b0;
    #1;
    chk("mid_rst_cyc", 32'(bus.CYC_O), 32'd0);
    chk("mid_rst_stb", 32'(bus.STB_O), 32'd0);
    chk("mid_rst_rvalid", 32'(bus.rdat_valid), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk("mid_rst_no_pulse", 32'({bus.done, bus.err}), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("mid_rst_release_ready", 32'(bus.cmd_ready), 32'd1);
    rv = '{1'b0, 8'h05, 4'd0, 0, 0, 0, 1'b1, 1'b0, 1, 8'h05};
    run_burst(rv, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
